skinny_share_codec: RTL and testbench
=====================================

# skinny_share_codec

Boundary block between the unmasked domain and the 3-share second-order masked SKINNY-64 S-box datapath. It accepts a 64-bit unshared state and splits each nibble into three Boolean shares using fresh randomness. It streams the shares serially, one nibble per cycle, into the masked S-box pipeline, collects the returning 3-share results after a fixed pipeline latency, and recombines them into a 64-bit unshared result. It is the producer/consumer end of the share interface that the masked S-box stages implement.

## Interface

Parameters:
- LAT, 4, pipeline latency of the attached masked S-box datapath in clock cycles; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data; high only in IDLE
- in_data  input  64  unshared state; nibble k = in_data[4k+3:4k]
- rnd  input  8  fresh masking randomness, consumed on every launch edge
- rnd_req  output  1  high in every cycle whose closing edge consumes rnd; external PRNG advances on it
- sb_in1, sb_in2, sb_in3  output  4 each  registered shares of the nibble being launched
- sb_out1, sb_out2, sb_out3  input  4 each  shares returned by the datapath
- out_valid  output  1  out_data holds a complete result
- out_ready  input  1  downstream accepts out_data
- out_data  output  64  recombined result; nibble j = sb_out1^sb_out2^sb_out3 captured for nibble j

## Operation

- States: IDLE, SEND, DRAIN, DONE. A single cycle counter t, 5 bits wide, counts 0..15+LAT.
- IDLE: in_ready=1. On an edge with in_valid=1, latch in_data, clear t to 0, and move to SEND. in_valid while not in IDLE is ignored.
- Launch: on every edge in SEND with t<16, load nibble x=data[t]:
  - sb_in1 = rnd[3:0]
  - sb_in2 = rnd[7:4]
  - sb_in3 = x ^ rnd[3:0] ^ rnd[7:4]
- rnd_req is 1 exactly during the SEND cycles whose closing edge performs a launch.
- Capture: on every edge with t>=LAT in SEND or DRAIN, write nibble t-LAT of out_data as sb_out1^sb_out2^sb_out3. Recombination happens only at capture. No unshared intermediate is registered elsewhere.
- t increments on every edge in SEND and DRAIN.
- SEND moves to DRAIN on the edge that launches nibble 15.
- DRAIN moves to DONE on the edge that captures nibble 15 (t=15+LAT).
- If LAT=1, the capture of nibble 15 happens on the edge after the launch of nibble 15; DRAIN lasts one cycle.
- After the launch of nibble 15, sb_in1..3 return to 4'h0 on the next edge and stay 0 outside SEND.
- DONE: out_valid=1 and out_data is held stable. On an edge with out_ready=1, move to IDLE. out_valid drops on that edge and out_data keeps its value. in_ready stays 0 in DONE; there is no overlap between blocks.
- Reset: state IDLE, t=0, latched data=0, sb_in1..3=0, out_data=0, out_valid=0, rnd_req=0, in_ready=1 once rst_n is released.
- Reset asserted mid-block clears everything immediately. Partial results are discarded and no out_valid is produced for that block.

## Timing

- Accept edge E0. Nibble k is launched on edge E0+1+k, for k=0..15.
- Nibble j is captured on edge E0+1+j+LAT.
- out_valid rises after edge E0+16+LAT, so accept-to-valid latency is 16+LAT cycles.
- Earliest next accept is the edge after the out_ready handshake edge.
- rnd is sampled on exactly 16 edges per block, E0+1..E0+16.

## Test plan

- Identity datapath model (sb_out = sb_in delayed LAT cycles), LAT=4, in_data=64'h0123456789ABCDEF, rnd random -> out_data=64'h0123456789ABCDEF, out_valid rises 20 cycles after accept.
- Share check: nibble 0 = 4'h3, rnd=8'hA5 at the launch edge -> sb_in1=4'h5, sb_in2=4'hA, sb_in3=4'hC.
- Unshared SKINNY S-box reference model with output split into shares, LAT=4, in_data=0 -> out_data=64'hCCCCCCCCCCCCCCCC.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, and an in_valid pulse in this window is ignored. out_ready=1 -> IDLE on the next edge.
- rst_n pulsed low 5 cycles after accept -> all outputs return to reset values asynchronously, no out_valid follows, and a fresh block afterwards completes correctly.
- Rebuild with LAT=1 and LAT=15 -> correct out_data, latencies of 17 and 31 cycles, rnd_req high for exactly 16 cycles per block.

Source files
------------

// File: rtl/skinny_share_codec.sv
// Share codec between the unmasked domain and a 3-share masked SKINNY-64 S-box pipeline.
// Splits 16 nibbles into Boolean shares, streams them one per cycle, and recombines the returning shares.
module skinny_share_codec #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [7:0]  rnd,
    output logic        rnd_req,
    output logic [3:0]  sb_in1,
    output logic [3:0]  sb_in2,
    output logic [3:0]  sb_in3,
    input  logic [3:0]  sb_out1,
    input  logic [3:0]  sb_out2,
    input  logic [3:0]  sb_out3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only while idle, out_valid only while a finished result is held.

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    localparam logic [4:0] LAT5   = 5'(LAT);
    localparam logic [4:0] LAST_T = 5'(15 + LAT);

    state_t      state_q, state_d;
    logic [4:0]  t_q, t_d;
    logic [63:0] data_q, data_d;
    logic [11:0] sb_q, sb_d;
    logic [63:0] out_q, out_d;
    logic [3:0]  x;
    logic [3:0]  cap_idx;
    logic        capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 5'd0;
            data_q  <= 64'h0;
            sb_q    <= 12'h0;
            out_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            data_q  <= data_d;
            sb_q    <= sb_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        data_d  = data_q;
        sb_d    = 12'h0;
        out_d   = out_q;
        x       = data_q[{t_q[3:0], 2'b00} +: 4];
        cap_idx = 4'(t_q - LAT5);
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    t_d     = 5'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Every SEND cycle launches nibble t; the two random nibbles mask it.
                sb_d = {x ^ rnd[3:0] ^ rnd[7:4], rnd[7:4], rnd[3:0]};
                t_d  = t_q + 5'd1;
                if (t_q == 5'd15) state_d = DRAIN;
            end
            DRAIN: begin
                t_d = t_q + 5'd1;
                if (t_q == LAST_T) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        capture = ((state_q == SEND) || (state_q == DRAIN)) && (t_q >= LAT5);
        // Shares are recombined only here, straight into the result register.
        if (capture) out_d[{cap_idx, 2'b00} +: 4] = sb_out1 ^ sb_out2 ^ sb_out3;
    end

    assign in_ready  = (state_q == IDLE);
    assign rnd_req   = (state_q == SEND);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign sb_in1    = sb_q[3:0];
    assign sb_in2    = sb_q[7:4];
    assign sb_in3    = sb_q[11:8];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_skinny_share_codec.sv
// Bench for skinny_share_codec: three instances (LAT 4, 1, 15) against a cycle-level behavioural model.
module tb_skinny_share_codec;

    localparam int NL = 3;
    localparam int LATS[NL] = '{4, 1, 15};
    localparam logic [3:0] SB[16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                      4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid[NL], in_ready[NL], rnd_req[NL], out_valid[NL], out_ready[NL];
    logic [63:0] in_data[NL], out_data[NL];
    logic [7:0]  rnd[NL];
    logic [3:0]  sb_in1[NL], sb_in2[NL], sb_in3[NL];
    logic [3:0]  sb_out1[NL], sb_out2[NL], sb_out3[NL];
    logic [1:0]  dbg_state[NL];

    int total = 0;
    int bad = 0;
    bit sbox_mode = 1'b0;
    bit pin_rnd[NL] = '{default: 1'b0};

    function automatic logic [3:0] sbox(input logic [3:0] v);
        return SB[v];
    endfunction

    function automatic logic [63:0] expect_fn(input logic [63:0] d, input bit mode);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[k*4 +: 4] = mode ? sbox(d[k*4 +: 4]) : d[k*4 +: 4];
        return r;
    endfunction

    task automatic chk(input string nm, input int l, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d (LAT=%0d) act=%h exp=%h t=%0t", nm, l, LATS[l], act, exp, $time);
        end
    endtask

    // DUTs and attached datapath models (LAT-1 register stages, capture edge is LAT after launch)
    for (genvar g = 0; g < NL; g++) begin : g_lane
        logic [11:0] dl[16];
        logic [11:0] cur;
        logic [11:0] tap;

        skinny_share_codec #(.LAT(LATS[g])) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .rnd(rnd[g]), .rnd_req(rnd_req[g]),
            .sb_in1(sb_in1[g]), .sb_in2(sb_in2[g]), .sb_in3(sb_in3[g]),
            .sb_out1(sb_out1[g]), .sb_out2(sb_out2[g]), .sb_out3(sb_out3[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
            .dbg_state(dbg_state[g])
        );

        assign cur = {sb_in3[g], sb_in2[g], sb_in1[g]};
        always @(posedge clk) begin
            dl[0] <= cur;
            for (int i = 1; i < 16; i++) dl[i] <= dl[i-1];
        end
        assign tap = (LATS[g] == 1) ? cur : dl[(LATS[g] >= 2) ? LATS[g] - 2 : 0];
        // S-box mode re-splits the unshared S-box output into a different share triple
        assign sb_out1[g] = sbox_mode ? tap[7:4] : tap[3:0];
        assign sb_out2[g] = sbox_mode ? tap[3:0] : tap[7:4];
        assign sb_out3[g] = sbox_mode ? (sbox(tap[3:0] ^ tap[7:4] ^ tap[11:8]) ^ tap[3:0] ^ tap[7:4])
                                      : tap[11:8];
    end

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (pin_rnd[l]) begin
                rnd[l] = 8'hA5;
                pin_rnd[l] = 1'b0;
            end else begin
                rnd[l] = 8'($urandom);
            end
        end
    end

    // behavioural model: d = edges since accept; launches at d=1..16, result at d=16+LAT
    bit          busy[NL] = '{default: 1'b0};
    int          d[NL] = '{default: 0};
    bit [63:0]   mdata[NL] = '{default: '0};
    bit [63:0]   mexp[NL] = '{default: '0};
    bit [63:0]   mhold[NL] = '{default: '0};
    bit [7:0]    lrnd[NL] = '{default: '0};
    bit [3:0]    lnib[NL] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst_n) begin
                busy[l] = 1'b0;
                d[l] = 0;
                mhold[l] = '0;
            end else if (!busy[l]) begin
                if (in_valid[l]) begin
                    busy[l] = 1'b1;
                    d[l] = 0;
                    mdata[l] = in_data[l];
                    mexp[l] = expect_fn(in_data[l], sbox_mode);
                end
            end else begin
                d[l]++;
                if (d[l] <= 16) begin
                    lrnd[l] = rnd[l];
                    lnib[l] = mdata[l][(d[l]-1)*4 +: 4];
                end
                if (d[l] == 16 + LATS[l]) mhold[l] = mexp[l];
                else if (d[l] > 16 + LATS[l] && out_ready[l]) busy[l] = 1'b0;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            chk("in_ready", l, in_ready[l], !busy[l]);
            chk("out_valid", l, out_valid[l], busy[l] && d[l] >= 16 + LATS[l]);
            chk("rnd_req", l, rnd_req[l], busy[l] && d[l] <= 15);
            if (busy[l] && d[l] >= 1 && d[l] <= 16) begin
                chk("sb_in1", l, sb_in1[l], lrnd[l][3:0]);
                chk("sb_in2", l, sb_in2[l], lrnd[l][7:4]);
                chk("sb_xor", l, sb_in1[l] ^ sb_in2[l] ^ sb_in3[l], lnib[l]);
            end else begin
                chk("sb_idle", l, {sb_in3[l], sb_in2[l], sb_in1[l]}, 12'h0);
            end
            if (!busy[l] || d[l] >= 16 + LATS[l]) chk("out_data", l, out_data[l], mhold[l]);
        end
    end

    // driver: one full block on lane l, optionally pinning rnd for the first launch
    task automatic run_block(input int l, input logic [63:0] data, input int hold, input bit pin,
                             output logic [63:0] res);
        int m;
        int nreq;
        @(negedge clk);
        in_valid[l] = 1'b1;
        in_data[l] = data;
        out_ready[l] = 1'b0;
        @(posedge clk);
        #1;
        if (pin) pin_rnd[l] = 1'b1;
        m = 0;
        nreq = 0;
        @(negedge clk);
        in_valid[l] = 1'b0;
        while (!out_valid[l] && m < 100) begin
            if (rnd_req[l]) nreq++;
            if (pin && m == 1) begin
                chk("pin_sb_in1", l, sb_in1[l], 4'h5);
                chk("pin_sb_in2", l, sb_in2[l], 4'hA);
                chk("pin_sb_in3", l, sb_in3[l], 4'hC);
            end
            m++;
            @(negedge clk);
        end
        chk("latency", l, m, 16 + LATS[l]);
        chk("rnd_req_cycles", l, nreq, 16);
        for (int i = 0; i < hold; i++) begin
            in_valid[l] = (i == 2);
            in_data[l] = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid[l] = 1'b0;
        res = out_data[l];
        out_ready[l] = 1'b1;
        @(negedge clk);
        out_ready[l] = 1'b0;
        chk("in_ready_after_hs", l, in_ready[l], 1'b1);
        chk("out_valid_after_hs", l, out_valid[l], 1'b0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] dat;
        int l;
        int seen;
        for (int i = 0; i < NL; i++) begin
            in_valid[i] = 1'b0;
            in_data[i] = '0;
            out_ready[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sbox_mode = 1'b0;
        for (int i = 0; i < NL; i++) begin
            run_block(i, 64'h0123456789ABCDEF, 0, 1'b0, res);
            chk("identity_literal", i, res, 64'h0123456789ABCDEF);
        end
        run_block(0, 64'hFEDCBA9876543213, 0, 1'b1, res);
        chk("pin_block_literal", 0, res, 64'hFEDCBA9876543213);

        sbox_mode = 1'b1;
        for (int i = 0; i < NL; i++) begin
            run_block(i, 64'h0, 0, 1'b0, res);
            chk("sbox_zero_literal", i, res, 64'hCCCCCCCCCCCCCCCC);
        end

        dat = {$urandom, $urandom};
        run_block(0, dat, 10, 1'b0, res);
        chk("backpressure_result", 0, res, expect_fn(dat, 1'b1));

        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(0, NL - 1);
            sbox_mode = 1'($urandom_range(0, 1));
            dat = {$urandom, $urandom};
            run_block(l, dat, $urandom_range(0, 4), 1'b0, res);
            chk("random_result", l, res, expect_fn(dat, sbox_mode));
        end

        // reset in the middle of a block
        sbox_mode = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0] = 64'h1122334455667788;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 0, in_ready[0], 1'b1);
        chk("rst_out_valid", 0, out_valid[0], 1'b0);
        chk("rst_rnd_req", 0, rnd_req[0], 1'b0);
        chk("rst_out_data", 0, out_data[0], 64'h0);
        chk("rst_sb_in", 0, {sb_in3[0], sb_in2[0], sb_in1[0]}, 12'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("no_valid_after_reset", 0, seen, 0);
        dat = {$urandom, $urandom};
        run_block(0, dat, 1, 1'b0, res);
        chk("post_reset_result", 0, res, dat);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
